// File: rtl/muldiv_pkg.sv
// Shared constants and types for the execute-stage iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DATA_W   = 32;
  localparam int ITER_CNT = 32;
  localparam int CNT_W    = 5;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: magnitude datapath, one bit per cycle,
// sign fix-up in a final cycle, 64-bit result presented on outHi/outLo.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] inRD1,
  input  logic [DATA_W-1:0] inRD2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] outHi,
  output logic [DATA_W-1:0] outLo
);

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [63:0]      acc_r;
  logic [31:0]      opb_r;
  logic [1:0]       op_r;
  logic             res_neg_r;
  logic             rem_neg_r;
  logic             div0_r;
  logic [31:0]      dividend_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic             busy_r;
  logic             done_r;

  logic             accept_s;
  logic             signed_s;
  logic             is_div_s;
  logic [31:0]      mag_a_s;
  logic [31:0]      mag_b_s;
  logic [32:0]      mul_sum_s;
  logic [32:0]      div_shift_s;
  logic [32:0]      div_diff_s;
  logic [63:0]      acc_step_s;
  logic [63:0]      prod_fix_s;
  logic [31:0]      fix_hi_s;
  logic [31:0]      fix_lo_s;

  // Next-state logic; start only counts in IDLE or DONE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s  = ST_CALC;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIX:  state_s = ST_DONE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand conditioning at acceptance plus one shift-add / restoring-divide step.
  always_comb begin
    signed_s    = (op == OP_MULT) || (op == OP_DIV);
    is_div_s    = op[1];
    mag_a_s     = mag32(inRD1, signed_s);
    mag_b_s     = mag32(inRD2, signed_s);
    mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opb_r} : 33'd0);
    div_shift_s = {acc_r[63:32], acc_r[31]};
    div_diff_s  = div_shift_s - {1'b0, opb_r};
    if (op_r[1]) begin
      if (!div_diff_s[32]) begin
        acc_step_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
      end else begin
        acc_step_s = {div_shift_s[31:0], acc_r[30:0], 1'b0};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_r[31:1]};
    end
  end

  // Sign restoration; a zero divisor overrides everything with the fixed pattern.
  always_comb begin
    prod_fix_s = cneg64(acc_r, res_neg_r);
    if (op_r[1]) begin
      if (div0_r) begin
        fix_hi_s = dividend_r;
        fix_lo_s = 32'hFFFF_FFFF;
      end else begin
        fix_hi_s = cneg32(acc_r[63:32], rem_neg_r);
        fix_lo_s = cneg32(acc_r[31:0], res_neg_r);
      end
    end else begin
      fix_hi_s = prod_fix_s[63:32];
      fix_lo_s = prod_fix_s[31:0];
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= 64'd0;
      opb_r      <= 32'd0;
      op_r       <= 2'b00;
      res_neg_r  <= 1'b0;
      rem_neg_r  <= 1'b0;
      div0_r     <= 1'b0;
      dividend_r <= 32'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_CALC) || (state_s == ST_FIX);
      done_r  <= (state_s == ST_DONE);
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            op_r       <= op;
            acc_r      <= {32'd0, (is_div_s ? mag_a_s : mag_b_s)};
            opb_r      <= is_div_s ? mag_b_s : mag_a_s;
            res_neg_r  <= signed_s & (inRD1[31] ^ inRD2[31]);
            rem_neg_r  <= signed_s & is_div_s & inRD1[31];
            div0_r     <= is_div_s & (inRD2 == 32'd0);
            dividend_r <= inRD1;
            cnt_r      <= CNT_W'(ITER_CNT - 1);
          end else begin
            cnt_r      <= cnt_r;
          end
        end
        ST_CALC: begin
          acc_r <= acc_step_s;
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_FIX: begin
          hi_r <= fix_hi_s;
          lo_r <= fix_lo_s;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign outHi = hi_r;
  assign outLo = lo_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: results and issue cycles queued at acceptance,
// checked when done pulses (value, 34-cycle latency, single-cycle pulse).
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] inRD1;
  logic [31:0] inRD2;
  logic        busy;
  logic        done;
  logic [31:0] outHi;
  logic [31:0] outLo;

  ex_muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .inRD1 (inRD1),
    .inRD2 (inRD2),
    .busy  (busy),
    .done  (done),
    .outHi (outHi),
    .outLo (outLo)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          issue_cnt = 0;
  logic        prev_done = 1'b0;
  logic [63:0] exp_q[$];
  int          cyc_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Caller sits just after a falling edge; returns one cycle later.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    start = 1'b1;
    op    = o;
    inRD1 = a;
    inRD2 = b;
    exp_q.push_back(exp);
    cyc_q.push_back(cyc);
    issue_cnt++;
    @(negedge clk);
    start = 1'b0;
    inRD1 = $urandom;
    inRD2 = $urandom;
    chk("busy_rise", {63'd0, busy}, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard side: every done pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    logic [63:0] e;
    int          c;
    if (rst_n && done) begin
      done_cnt++;
      chk("done_width", {63'd0, prev_done}, 64'd0);
      chk("busy_in_done", {63'd0, busy}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_done", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("result", {outHi, outLo}, e);
        chk("latency", 64'(cyc - c), 64'd34);
      end
    end
    prev_done = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = OP_MULTU;
    inRD1 = 32'd0;
    inRD2 = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_out", {outHi, outLo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
    drain();
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 64'h0000_0002_FFFF_FFFA);
    drain();
    issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
    drain();
    issue(OP_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E);
    drain();
    issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF);
    drain();
    issue(OP_DIVU,  32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF);
    drain();
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    drain();
    issue(OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    drain();

    // Asynchronous reset in cycle 10 of an operation.
    @(negedge clk);
    issue(OP_MULTU, 32'd3, 32'd5, 64'd15);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_out", {outHi, outLo}, 64'd0);
    void'(exp_q.pop_back());
    void'(cyc_q.pop_back());
    issue_cnt--;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'd15);
    drain();

    // start pulsed in cycle 5 of an operation must be ignored.
    @(negedge clk);
    issue(OP_MULTU, 32'd7, 32'd6, 64'd42);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = OP_DIV;
    inRD1 = 32'h0BAD_F00D;
    inRD2 = 32'h0000_0003;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    chk("done_count", 64'(done_cnt), 64'(issue_cnt));

    // Back-to-back: second op accepted in the DONE cycle of the first.
    issue(OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    chk("b2b_done_seen", {63'd0, done}, 64'd1);
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    for (int i = 0; i < 33; i++) begin
      chk("b2b_hold", {outHi, outLo}, 64'h0000_0002_0000_000E);
      chk("b2b_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
    end
    drain();
    repeat (5) @(negedge clk);
    chk("final_done_count", 64'(done_cnt), 64'(issue_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit for the execute stage, consuming operand pair and opcode captured from the ID/EX pipeline register outputs. Implements MULT, MULTU, DIV and DIVU with a fixed 34-cycle latency, writing a 64-bit result into HI/LO. Drives a busy signal that the hazard logic uses to stall the front of the pipeline.

## Interface
- DATA_W, 32, operand width; all arithmetic rules below assume 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on a rising edge only when the unit is in IDLE or DONE.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- inRD1  input  32  rs operand (multiplicand / dividend).
- inRD2  input  32  rt operand (multiplier / divisor).
- busy  output  1  high while an operation is in flight (CALC, FIX).
- done  output  1  single-cycle pulse; outHi/outLo hold the new result.
- outHi  output  32  MULT*: product[63:32]; DIV*: remainder.
- outLo  output  32  MULT*: product[31:0]; DIV*: quotient.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start=1: latch op, |operands| (signed ops) or raw operands (unsigned ops), result sign, remainder sign, divisor-zero flag, original dividend; iteration counter := 31; go to CALC.
- IDLE/DONE + start=0: go/stay IDLE.
- CALC: one iteration per cycle. Multiply: shift-add on 64-bit accumulator. Divide: restoring, 33-bit partial remainder, one quotient bit per cycle. Counter decrements; counter==0 on an edge -> FIX.
- FIX: negate product/quotient if result sign set; negate remainder if dividend negative (signed DIV only); register into outHi/outLo; -> DONE.
- DONE: done=1, busy=0; start accepted here for back-to-back ops.
- Divide-by-zero (DIV or DIVU): outLo=0xFFFFFFFF, outHi=original dividend (un-negated), regardless of signs.
- DIV 0x80000000 / 0xFFFFFFFF: outLo=0x80000000, outHi=0 (falls out of 32-bit unsigned magnitude path; no trap).
- start while busy=1: ignored, no effect on in-flight operation or latched operands.
- outHi/outLo change only on the FIX->DONE edge; hold between operations.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset (asynchronous, any state, including mid-CALC): state=IDLE, busy=0, done=0, outHi=0, outLo=0, counter=0, all internal accumulators 0; in-flight op discarded.
- Cycle 0: start=1 before edge. Cycles 1-32: CALC, busy=1. Cycle 33: FIX, busy=1. Cycle 34: DONE, done=1, busy=0, result valid.
- busy rises the cycle after acceptance; stall logic must treat start itself as busy-causing (combinational busy|start is the stall term, built outside this block).
- Back-to-back: start=1 in cycle 34 -> next done in cycle 68.
- done is never high for two consecutive cycles unless a zero-length case existed; none does.

## Structure
- muldiv_pkg: op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), state enum, DATA_W, ITER_CNT=32.
- Single module; no sub-module needed. Sign-magnitude pre/post conditioning kept as local functions inside it.

## Test plan
- Reset mid-CALC (cycle 10): -> busy=0, done=0, outHi=outLo=0 immediately; next start completes normally in 34 cycles.
- MULT 0xFFFFFFFE x 0x00000003 -> cycle 34: outHi=0xFFFFFFFF, outLo=0xFFFFFFFA, done=1 one cycle; MULTU same operands -> outHi=0x00000002, outLo=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> outLo=0xFFFFFFFD (-3), outHi=0xFFFFFFFF (-1); DIVU 100/7 -> outLo=14, outHi=2.
- DIV 0xFFFFFFF9 / 0 -> outLo=0xFFFFFFFF, outHi=0xFFFFFFF9; DIV 0x80000000 / 0xFFFFFFFF -> outLo=0x80000000, outHi=0.
- start pulsed in cycle 5 during an operation with different operands -> ignored; original result at cycle 34, no second done.
- start in DONE cycle (back-to-back MULTU 0x10000 x 0x10000) -> busy next cycle, done cycle 68 with outHi=1, outLo=0; prior result held through cycles 35-67.
